mac_cyv_skew_feeder: RTL and testbench

//  Upstream operand feeder for a column/row of mac_cyv half-float MAC cells.

---
 rtl/mac_cyv_pkg.sv | 20 ++
 rtl/mac_cyv_skew_feeder_if.sv | 17 +
 rtl/mac_cyv_vec_fifo.sv | 61 ++++++
 rtl/mac_cyv_skew_feeder.sv | 119 +++++++++++
 tb/tb_mac_cyv_skew_feeder.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_cyv_pkg.sv
// mac_cyv_pkg
//   Shared half-float definitions for the mac_cyv operand feeder slice.
//   Provides the half_t type, exponent/mantissa widths, the all-ones
//   exponent marker and a helper that spots Inf/NaN encodings.
package mac_cyv_pkg;

  localparam int HALF_EXP_W = 5;
  localparam int HALF_MAN_W = 10;

  typedef logic [HALF_EXP_W+HALF_MAN_W:0] half_t;

  localparam logic [HALF_EXP_W-1:0] HALF_EXP_MAX = 5'h1F;
  localparam half_t                 HALF_ZERO    = 16'h0000;

  // True for Inf and NaN: exponent field saturated, mantissa ignored.
  function automatic logic is_half_special(input half_t h);
    return (h[HALF_MAN_W +: HALF_EXP_W] == HALF_EXP_MAX);
  endfunction

endpackage

// File: rtl/mac_cyv_skew_feeder_if.sv
// mac_cyv_skew_feeder_if
//   Input vector stream of the skew feeder (valid/ready handshake).
//   Ports: in_valid (vector offered), in_ready (feeder can accept),
//          in_data (N_LANES half-floats, lane i at [i*16 +: 16]).
//   Modports: master = producer side, slave = feeder side.
interface mac_cyv_skew_feeder_if #(
  parameter int N_LANES = 4
) ();
  import mac_cyv_pkg::*;

  logic                           in_valid;
  logic                           in_ready;
  logic [N_LANES*$bits(half_t)-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/mac_cyv_vec_fifo.sv
// mac_cyv_vec_fifo
//   Synchronous FIFO of DEPTH entries, each WIDTH bits wide.
//   Ports: clk, areset (async, active-high), push/wdata (write request),
//          pop (read request), rdata (head entry, valid when !empty),
//          full, empty, level (entries currently held, 0..DEPTH).
//   Requests against a full/empty FIFO are dropped; no write-to-read bypass.
module mac_cyv_vec_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (level_r == LVL_MAX);
  assign empty  = (level_r == '0);
  assign level  = level_r;
  assign rdata  = mem_r[rd_ptr_r];
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // Storage, pointers (wrap naturally at power-of-2 DEPTH) and occupancy.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < DEPTH; k++) mem_r[k] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end
endmodule

// File: rtl/mac_cyv_skew_feeder.sv
// mac_cyv_skew_feeder
//   Operand feeder for a chain of mac_cyv half-float MAC cells. Whole
//   operand vectors are buffered in a small FIFO; on each enabled cycle the
//   head vector is popped into a head register, then lane i travels through
//   i+1 skew registers so it meets the i-th MAC's chained sum. Empty cycles
//   inject +0.0 with valid low.
//   Ports: clk, areset (async, active-high), en (advance enable),
//          in_if (slave: in_valid/in_ready/in_data), out_a (skewed operands),
//          out_valid (per-lane valid), fifo_level (buffered vectors),
//          sanitize_flag (sticky Inf/NaN seen).
//   Option: MAC_CYV_FEED_SANITIZE_EN replaces Inf/NaN elements by +0.0 at
//   pop and raises sanitize_flag; without it data passes bit-exact and the
//   flag is tied low.
module mac_cyv_skew_feeder
  import mac_cyv_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int DEPTH   = 4,
  parameter int HALF_W  = 16
) (
  input  logic                        clk,
  input  logic                        areset,
  input  logic                        en,
  mac_cyv_skew_feeder_if.slave        in_if,
  output logic [N_LANES*HALF_W-1:0]   out_a,
  output logic [N_LANES-1:0]          out_valid,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        sanitize_flag
);
  localparam int VW = N_LANES * HALF_W;

  logic [VW-1:0] fifo_rdata_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          pop_s;
  logic [VW-1:0] head_data_s;
  logic [VW-1:0] head_data_r;
  logic          head_valid_r;

  mac_cyv_vec_fifo #(.DEPTH(DEPTH), .WIDTH(VW)) u_fifo (
    .clk    (clk),
    .areset (areset),
    .push   (in_if.in_valid),
    .wdata  (in_if.in_data),
    .pop    (en),
    .rdata  (fifo_rdata_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .level  (fifo_level)
  );

  assign in_if.in_ready = !fifo_full_s;
  // Pop decision uses the occupancy before this edge's push.
  assign pop_s = en && !fifo_empty_s;

`ifdef MAC_CYV_FEED_SANITIZE_EN
  logic special_s;

  // Replace Inf/NaN elements of the head vector with +0.0.
  always_comb begin
    head_data_s = fifo_rdata_s;
    special_s   = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      if (is_half_special(fifo_rdata_s[i*HALF_W +: HALF_W])) begin
        head_data_s[i*HALF_W +: HALF_W] = HALF_ZERO;
        special_s = 1'b1;
      end else begin
        head_data_s[i*HALF_W +: HALF_W] = fifo_rdata_s[i*HALF_W +: HALF_W];
      end
    end
  end

  // Sticky flag: set on the edge a special element is popped.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sanitize_flag <= 1'b0;
    end else if (pop_s && special_s) begin
      sanitize_flag <= 1'b1;
    end
  end
`else
  assign head_data_s   = fifo_rdata_s;
  assign sanitize_flag = 1'b0;
`endif

  // Head register: popped vector or a zero bubble; frozen while en is low.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      head_data_r  <= '0;
      head_valid_r <= 1'b0;
    end else if (en) begin
      head_data_r  <= pop_s ? head_data_s : '0;
      head_valid_r <= pop_s;
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic [HALF_W-1:0] data_r [i+1];
    logic [i:0]        vld_r;

    // Lane i shift chain of i+1 stages; the last stage drives the output.
    always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
        for (int k = 0; k <= i; k++) data_r[k] <= '0;
        vld_r <= '0;
      end else if (en) begin
        data_r[0] <= head_data_r[i*HALF_W +: HALF_W];
        vld_r[0]  <= head_valid_r;
        for (int k = 1; k <= i; k++) begin
          data_r[k] <= data_r[k-1];
          vld_r[k]  <= vld_r[k-1];
        end
      end
    end

    assign out_a[i*HALF_W +: HALF_W] = data_r[i];
    assign out_valid[i]              = vld_r[i];
  end
endmodule

// File: tb/tb_mac_cyv_skew_feeder.sv
// tb_mac_cyv_skew_feeder
//   Directed bench for mac_cyv_skew_feeder (N_LANES=4, DEPTH=4) plus a
//   random valid/en phase scored against a queue model. Expectations for
//   the Inf/NaN option follow MAC_CYV_FEED_SANITIZE_EN.
module tb_mac_cyv_skew_feeder;

`ifdef MAC_CYV_FEED_SANITIZE_EN
  localparam bit SAN = 1'b1;
`else
  localparam bit SAN = 1'b0;
`endif

  logic        clk;
  logic        areset;
  logic        en;
  logic [63:0] out_a;
  logic [3:0]  out_valid;
  logic [2:0]  fifo_level;
  logic        sanitize_flag;

  int tests_run    = 0;
  int tests_failed = 0;

  mac_cyv_skew_feeder_if #(.N_LANES(4)) ifc ();

  mac_cyv_skew_feeder #(.N_LANES(4), .DEPTH(4), .HALF_W(16)) dut (
    .clk           (clk),
    .areset        (areset),
    .en            (en),
    .in_if         (ifc),
    .out_a         (out_a),
    .out_valid     (out_valid),
    .fifo_level    (fifo_level),
    .sanitize_flag (sanitize_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mkvec(input int j);
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(32'h1000 * (j + 1) + i);
    return v;
  endfunction

  function automatic logic [63:0] san_vec(input logic [63:0] d);
    logic [63:0] v;
    v = d;
    for (int i = 0; i < 4; i++)
      if (SAN && d[i*16+10 +: 5] == 5'h1F) v[i*16 +: 16] = 16'h0000;
    return v;
  endfunction

  function automatic logic has_special(input logic [63:0] d);
    logic s;
    s = 1'b0;
    for (int i = 0; i < 4; i++) if (d[i*16+10 +: 5] == 5'h1F) s = 1'b1;
    return s;
  endfunction

  function automatic logic [15:0] lane(input int i);
    return out_a[i*16 +: 16];
  endfunction

  // Scoreboard state for the random phase.
  logic [63:0] vq[$];
  logic        vspec[$];
  int          rd_idx[4];
  int          pop_idx;
  int          mlevel;
  logic        mflag;

  task automatic cyc(input logic v, input logic [63:0] d, input logic e);
    logic do_push, do_pop;
    logic [63:0] ev;
    ifc.in_valid = v;
    ifc.in_data  = d;
    en           = e;
    do_push = v && (mlevel < 4);
    do_pop  = e && (mlevel > 0);
    check("m_ready", 64'(ifc.in_ready), 64'(mlevel < 4));
    step();
    if (do_pop) begin
      if (SAN && vspec[pop_idx]) mflag = 1'b1;
      pop_idx++;
    end
    if (do_push) begin
      vq.push_back(san_vec(d));
      vspec.push_back(has_special(d));
    end
    mlevel = mlevel + int'(do_push) - int'(do_pop);
    check("m_level", 64'(fifo_level), 64'(mlevel));
    check("m_flag", 64'(sanitize_flag), 64'(mflag));
    if (e) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i]) begin
          if (rd_idx[i] < vq.size()) begin
            ev = vq[rd_idx[i]];
            check("m_lane", 64'(lane(i)), 64'(ev[i*16 +: 16]));
          end else begin
            check("m_extra", 64'(1), 64'(0));
          end
          rd_idx[i]++;
        end
      end
    end
  endtask

  logic [63:0] s1;
  logic [63:0] s5;
  logic [63:0] exp5;

  initial begin
    s1 = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    s5 = {16'hFC00, 16'h3C00, 16'h7E01, 16'h7C00};
    areset = 1'b1;
    en = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data = '0;
    #2;
    check("rst_out_a", out_a, 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_level", 64'(fifo_level), 64'h0);
    check("rst_ready", 64'(ifc.in_ready), 64'h1);
    check("rst_flag", 64'(sanitize_flag), 64'h0);
    @(negedge clk);
    areset = 1'b0;

    // Scenario 1: latency per lane.
    en = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_data = s1;
    step();
    ifc.in_valid = 1'b0;
    check("s1_level", 64'(fifo_level), 64'h1);
    step();
    check("s1_e1_valid", 64'(out_valid), 64'h0);
    step();
    check("s1_lane0", 64'(lane(0)), 64'h3C00);
    check("s1_e2_valid", 64'(out_valid), 64'h1);
    step();
    check("s1_lane1", 64'(lane(1)), 64'h4000);
    check("s1_e3_valid", 64'(out_valid), 64'h2);

    // Scenario 3: stall while filling, then drain.
    en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data = mkvec(j);
      step();
      check("s3_level", 64'(fifo_level), 64'((j + 1 > 4) ? 4 : j + 1));
      check("s3_hold_valid", 64'(out_valid), 64'h2);
      check("s3_hold_lane1", 64'(lane(1)), 64'h4000);
    end
    ifc.in_valid = 1'b0;
    check("s3_ready_full", 64'(ifc.in_ready), 64'h0);
    for (int j = 0; j < 5; j++) step();
    check("s3_level_full", 64'(fifo_level), 64'h4);
    check("s3_frozen", out_a, 64'h0000_0000_4000_0000);
    en = 1'b1;
    step();
    check("s3_lane2", 64'(lane(2)), 64'h4200);
    check("s3_e1_valid", 64'(out_valid), 64'h4);
    check("s3_e1_level", 64'(fifo_level), 64'h3);
    check("s3_e1_ready", 64'(ifc.in_ready), 64'h1);
    step();
    check("s3_lane3", 64'(lane(3)), 64'h4400);
    check("s3_e2_v0", 64'(lane(0)), 64'h1000);
    check("s3_e2_valid", 64'(out_valid), 64'h9);
    step();
    check("s3_e3_v1", 64'(lane(0)), 64'h2000);
    step();
    check("s3_e4_v2", 64'(lane(0)), 64'h3000);
    step();
    check("s3_e5_out", out_a, 64'h1003_2002_3001_4000);
    check("s3_e5_valid", 64'(out_valid), 64'hF);
    step();
    check("s3_e6_valid", 64'(out_valid), 64'hE);
    check("s3_e6_bubble", 64'(lane(0)), 64'h0);
    for (int j = 0; j < 3; j++) step();
    check("s3_drained_valid", 64'(out_valid), 64'h0);
    check("s3_drained_out", out_a, 64'h0);
    check("s3_drained_level", 64'(fifo_level), 64'h0);

    // Scenario 4: reset mid-drain.
    en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data = mkvec(10 + j);
      step();
    end
    ifc.in_valid = 1'b0;
    en = 1'b1;
    step();
    step();
    check("s4_level", 64'(fifo_level), 64'h2);
    check("s4_valid", 64'(out_valid), 64'h1);
    check("s4_lane0", 64'(lane(0)), 64'hB000);
    #2 areset = 1'b1;
    #1;
    check("s4_rst_out", out_a, 64'h0);
    check("s4_rst_valid", 64'(out_valid), 64'h0);
    check("s4_rst_level", 64'(fifo_level), 64'h0);
    check("s4_rst_ready", 64'(ifc.in_ready), 64'h1);
    @(negedge clk);
    areset = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.in_data = s1;
    step();
    ifc.in_valid = 1'b0;
    step();
    step();
    check("s4_re_lane0", 64'(lane(0)), 64'h3C00);
    check("s4_re_valid0", 64'(out_valid), 64'h1);
    step();
    step();
    step();
    check("s4_re_lane3", 64'(lane(3)), 64'h4400);
    check("s4_re_valid3", 64'(out_valid), 64'h8);
    step();

    // Scenario 2: eight back-to-back vectors.
    for (int s = 0; s < 13; s++) begin
      ifc.in_valid = (s < 8);
      ifc.in_data = mkvec(20 + s);
      step();
      check("s2_ready", 64'(ifc.in_ready), 64'h1);
      check("s2_level_le1", 64'(fifo_level <= 3'd1), 64'h1);
      if (s >= 2 && s < 10) begin
        check("s2_lane0", 64'(lane(0)), 64'(mkvec(20 + s - 2) & 64'hFFFF));
        check("s2_v0", 64'(out_valid[0]), 64'h1);
      end
      if (s >= 5 && s < 13) begin
        check("s2_lane3", 64'(lane(3)), 64'(mkvec(20 + s - 5) >> 48));
        check("s2_v3", 64'(out_valid[3]), 64'h1);
      end
    end
    ifc.in_valid = 1'b0;

    // Scenario 5: Inf/NaN handling.
    exp5 = san_vec(s5);
    ifc.in_valid = 1'b1;
    ifc.in_data = s5;
    step();
    ifc.in_valid = 1'b0;
    check("s5_flag_pre", 64'(sanitize_flag), 64'h0);
    step();
    check("s5_flag_pop", 64'(sanitize_flag), 64'(SAN));
    for (int i = 0; i < 4; i++) begin
      step();
      check("s5_lane", 64'(lane(i)), 64'(exp5[i*16 +: 16]));
      check("s5_valid", 64'(out_valid), 64'(4'b0001 << i));
    end
    for (int j = 0; j < 3; j++) step();
    check("s5_flag_sticky", 64'(sanitize_flag), 64'(SAN));

    // Scenario 6: push+pop at level 2, then random traffic vs queue model.
    #2 areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    mlevel = 0;
    pop_idx = 0;
    mflag = 1'b0;
    for (int i = 0; i < 4; i++) rd_idx[i] = 0;
    cyc(1'b1, mkvec(40), 1'b0);
    cyc(1'b1, mkvec(41), 1'b0);
    cyc(1'b1, mkvec(42), 1'b1);
    check("s6_pp_level", 64'(fifo_level), 64'h2);
    for (int n = 0; n < 1000; n++)
      cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
    for (int n = 0; n < 12; n++) cyc(1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 4; i++) check("s6_all_seen", 64'(rd_idx[i]), 64'(vq.size()));
    check("s6_end_level", 64'(fifo_level), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
